// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory arbiter: boot/run state, port identity
// and the one-cycle response record that travels alongside the memory read.
package imem_pkg;

    typedef enum logic {BOOT, RUN} imem_state_e;

    typedef enum logic {PORT_IF, PORT_LD} imem_port_e;

    typedef struct packed {
        logic       valid;
        imem_port_e owner;
        logic       err;
        logic       is_write;
    } imem_resp_t;

    localparam imem_resp_t RESP_IDLE = '{valid: 1'b0, owner: PORT_IF, err: 1'b0, is_write: 1'b0};

endpackage

// File: rtl/imem_rr_arb2.sv
// Two-way round-robin grant between fetch and loader. While boot_mask is set
// only the loader may win; last_grant remembers the most recent winner.
module imem_rr_arb2
    import imem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_if,
    input  logic req_ld,
    input  logic boot_mask,
    output logic gnt_if,
    output logic gnt_ld
);

    imem_port_e last_q;

    always_comb begin
        // NOTE: every output is given a default first so no path through this block infers a latch.
        gnt_if = 1'b0;
        gnt_ld = 1'b0;
        // A request arriving together with reset is discarded, never granted.
        if (!rst) begin
            if (boot_mask) begin
                gnt_ld = req_ld;
            end else if (req_if && req_ld) begin
                gnt_if = (last_q == PORT_LD);
                gnt_ld = (last_q == PORT_IF);
            end else begin
                gnt_if = req_if;
                gnt_ld = req_ld;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register update from pre-edge values.
        if (rst) begin
            last_q <= PORT_LD;
        end else if (gnt_if) begin
            last_q <= PORT_IF;
        end else if (gnt_ld) begin
            last_q <= PORT_LD;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port, 1-cycle-latency instruction memory between fetch (IF)
// and the loader (LD), holding fetch off until the boot image is loaded.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int REG_SIZE       = 32,
    parameter int MEM_SIZE_IN_KB = 1,
    parameter int NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
    parameter int ADDR_W         = $clog2(NO_OF_REGS),
    parameter bit BOOT_HOLD      = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [REG_SIZE-1:0] if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [REG_SIZE-1:0] if_rdata_o,
    output logic                if_err_o,
    input  logic                ld_req_i,
    input  logic                ld_we_i,
    input  logic [3:0]          ld_be_i,
    input  logic [REG_SIZE-1:0] ld_addr_i,
    input  logic [REG_SIZE-1:0] ld_wdata_i,
    output logic                ld_gnt_o,
    output logic                ld_rvalid_o,
    output logic [REG_SIZE-1:0] ld_rdata_o,
    output logic                ld_err_o,
    input  logic                boot_done_i,
    output logic                booting_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [3:0]          mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [REG_SIZE-1:0] mem_wdata_o,
    input  logic [REG_SIZE-1:0] mem_rdata_i
);

    localparam logic [REG_SIZE-3:0] WORD_LIMIT = (REG_SIZE - 2)'(NO_OF_REGS);

    imem_state_e         state_q, state_d;
    imem_resp_t          resp_q, resp_d;
    logic                gnt_any;
    logic [REG_SIZE-1:0] sel_addr;
    logic                addr_err;
    logic                rdata_ok;

    always_comb begin
        state_d = state_q;
        if (state_q == BOOT && boot_done_i) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT_HOLD ? BOOT : RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign booting_o = (state_q == BOOT);

    imem_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_if    (if_req_i),
        .req_ld    (ld_req_i),
        .boot_mask (booting_o),
        .gnt_if    (if_gnt_o),
        .gnt_ld    (ld_gnt_o)
    );

    assign gnt_any  = if_gnt_o | ld_gnt_o;
    assign sel_addr = ld_gnt_o ? ld_addr_i : if_addr_i;
    // Misaligned or past-the-end requests are acknowledged with an error and never reach memory.
    assign addr_err = (sel_addr[1:0] != 2'b00) || (sel_addr[REG_SIZE-1:2] >= WORD_LIMIT);

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt_any && !addr_err) begin
            mem_en_o   = 1'b1;
            mem_addr_o = sel_addr[ADDR_W+1:2];
            if (ld_gnt_o) begin
                mem_we_o    = ld_we_i;
                mem_be_o    = ld_be_i;
                mem_wdata_o = ld_wdata_i;
            end else begin
                mem_be_o = 4'b1111;
            end
        end
    end

    always_comb begin
        resp_d = RESP_IDLE;
        if (gnt_any) begin
            resp_d.valid    = 1'b1;
            resp_d.owner    = ld_gnt_o ? PORT_LD : PORT_IF;
            resp_d.err      = addr_err;
            resp_d.is_write = ld_gnt_o & ld_we_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q <= RESP_IDLE;
        end else begin
            resp_q <= resp_d;
        end
    end

    // Read data is forwarded only for a successful read; writes and errors return zero.
    assign rdata_ok    = resp_q.valid && !resp_q.err && !resp_q.is_write;
    assign if_rvalid_o = resp_q.valid && (resp_q.owner == PORT_IF);
    assign ld_rvalid_o = resp_q.valid && (resp_q.owner == PORT_LD);
    assign if_err_o    = if_rvalid_o && resp_q.err;
    assign ld_err_o    = ld_rvalid_o && resp_q.err;
    assign if_rdata_o  = (if_rvalid_o && rdata_ok) ? mem_rdata_i : '0;
    assign ld_rdata_o  = (ld_rvalid_o && rdata_ok) ? mem_rdata_i : '0;

endmodule
